uart_tx_queue: RTL and testbench

UART_TX_QUEUE -- requirements
Module: uart_tx_queue

---
 rtl/uart_tx_queue.sv | 127 ++++++++++++
 tb/tb_uart_tx_queue.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_queue.sv
// rtl/uart_tx_queue.sv - byte FIFO feeding a UART transmitter via IDLE/START/WAIT handshake with timeout
// Optional: define UART_TX_QUEUE_ERR_DROP_EN to discard received bytes flagged by rx_err_i.
module uart_tx_queue #(
  parameter int          N          = 8,
  parameter int          DEPTH_LOG2 = 4,
  parameter logic [15:0] TIMEOUT    = 16'd20000
) (
  input  logic                  sysclk,
  input  logic                  reset_n,
  input  logic                  rx_end_i,
  input  logic                  rx_err_i,
  input  logic [N-1:0]          rx_data_i,
  input  logic                  tx_end_i,
  input  logic                  clr_ovf_i,
  output logic                  tx_start_o,
  output logic [N-1:0]          tx_data_o,
  output logic [DEPTH_LOG2:0]   count_o,
  output logic                  empty_o,
  output logic                  full_o,
  output logic                  overflow_o,
  output logic                  timeout_o
);
  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {IDLE, START, WAIT} state_t;

  state_t                r_state, w_next;
  logic [N-1:0]          r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wr_ptr, r_rd_ptr;
  logic [DEPTH_LOG2:0]   r_count, w_count_next;
  logic                  r_empty, r_full, r_ovf, r_tx_start, r_timeout;
  logic [N-1:0]          r_tx_data;
  logic [15:0]           r_timer;
  logic                  w_push_req, w_push, w_pop, w_ovf_event, w_timeout;

`ifdef UART_TX_QUEUE_ERR_DROP_EN
  assign w_push_req = rx_end_i && !rx_err_i;
`else
  logic w_unused_err;
  assign w_unused_err = rx_err_i;
  assign w_push_req   = rx_end_i;
`endif

  // A full FIFO still accepts a byte when the same edge frees a slot.
  assign w_push      = w_push_req && (!r_full || w_pop);
  assign w_ovf_event = w_push_req && r_full && !w_pop;

  always_comb begin
    w_next    = r_state;
    w_pop     = 1'b0;
    w_timeout = 1'b0;
    case (r_state)
      IDLE: begin
        if (!r_empty) begin
          w_pop  = 1'b1;
          w_next = START;
        end
      end
      START: w_next = WAIT;
      WAIT: begin
        if (tx_end_i) begin
          w_next = IDLE;
        end else if (r_timer == TIMEOUT - 16'd1) begin
          w_next    = IDLE;
          w_timeout = 1'b1;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_count_next = r_count;
    if (w_push && !w_pop) begin
      w_count_next = r_count + (DEPTH_LOG2+1)'(1);
    end else if (!w_push && w_pop) begin
      w_count_next = r_count - (DEPTH_LOG2+1)'(1);
    end
  end

  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_empty    <= 1'b1;
      r_full     <= 1'b0;
      r_ovf      <= 1'b0;
      r_tx_start <= 1'b0;
      r_timeout  <= 1'b0;
      r_tx_data  <= '0;
      r_timer    <= '0;
    end else begin
      r_state <= w_next;
      if (w_push) r_wr_ptr <= r_wr_ptr + DEPTH_LOG2'(1);
      if (w_pop) begin
        r_rd_ptr  <= r_rd_ptr + DEPTH_LOG2'(1);
        r_tx_data <= r_mem[r_rd_ptr];
      end
      r_count <= w_count_next;
      r_empty <= (w_count_next == '0);
      r_full  <= (w_count_next == DEPTH[DEPTH_LOG2:0]);
      // A fresh overflow wins over a clear on the same edge.
      if (w_ovf_event) begin
        r_ovf <= 1'b1;
      end else if (clr_ovf_i) begin
        r_ovf <= 1'b0;
      end
      r_tx_start <= (r_state == START);
      r_timeout  <= w_timeout;
      r_timer    <= (r_state == WAIT && w_next == WAIT) ? r_timer + 16'd1 : 16'd0;
    end
  end

  always_ff @(posedge sysclk) begin
    if (w_push) r_mem[r_wr_ptr] <= rx_data_i;
  end

  assign tx_start_o = r_tx_start;
  assign tx_data_o  = r_tx_data;
  assign count_o    = r_count;
  assign empty_o    = r_empty;
  assign full_o     = r_full;
  assign overflow_o = r_ovf;
  assign timeout_o  = r_timeout;
endmodule

// File: tb/tb_uart_tx_queue.sv
// tb/tb_uart_tx_queue.sv - randomized bench for uart_tx_queue against a queue-based transmit model
module tb_uart_tx_queue;
  localparam int DEPTH = 16;
  localparam int TO    = 100;

  logic       sysclk = 1'b0;
  logic       reset_n = 1'b0;
  logic       rx_end_i = 1'b0, rx_err_i = 1'b0, tx_end_i = 1'b0, clr_ovf_i = 1'b0;
  logic [7:0] rx_data_i = 8'h00;
  logic       tx_start_o, empty_o, full_o, overflow_o, timeout_o;
  logic [7:0] tx_data_o;
  logic [4:0] count_o;

  int checks = 0;
  int errors = 0;

  always #5 sysclk = ~sysclk;

  uart_tx_queue #(.N(8), .DEPTH_LOG2(4), .TIMEOUT(16'd100)) dut (
    .sysclk(sysclk), .reset_n(reset_n),
    .rx_end_i(rx_end_i), .rx_err_i(rx_err_i), .rx_data_i(rx_data_i),
    .tx_end_i(tx_end_i), .clr_ovf_i(clr_ovf_i),
    .tx_start_o(tx_start_o), .tx_data_o(tx_data_o), .count_o(count_o),
    .empty_o(empty_o), .full_o(full_o), .overflow_o(overflow_o), .timeout_o(timeout_o)
  );

  // Reference: pending bytes as a queue, plus the byte currently handed to the transmitter.
  logic [7:0] mq[$];
  logic [7:0] m_data;
  bit         m_busy, m_in_start, m_waiting, m_ovf, exp_start, exp_to;
  int         m_wait_cnt;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_data = 8'h00; m_busy = 0; m_in_start = 0; m_waiting = 0;
    m_ovf = 0; exp_start = 0; exp_to = 0; m_wait_cnt = 0;
  endtask

  task automatic model_edge(input bit rx, input bit err, input logic [7:0] d, input bit te, input bit clr);
    bit pop, full, push_req, ovf_ev;
    pop      = !m_busy && (mq.size() > 0);
    full     = (mq.size() == DEPTH);
    push_req = rx;
`ifdef UART_TX_QUEUE_ERR_DROP_EN
    if (err) push_req = 0;
`endif
    ovf_ev    = push_req && full && !pop;
    exp_start = m_in_start;
    exp_to    = 0;
    if (m_in_start) begin
      m_in_start = 0; m_waiting = 1; m_wait_cnt = 0;
    end else if (m_waiting) begin
      if (te) begin
        m_waiting = 0; m_busy = 0;
      end else if (m_wait_cnt == TO - 1) begin
        m_waiting = 0; m_busy = 0; exp_to = 1;
      end else begin
        m_wait_cnt++;
      end
    end
    if (pop) begin
      m_data = mq.pop_front(); m_busy = 1; m_in_start = 1;
    end
    if (push_req && !ovf_ev) mq.push_back(d);
    if (ovf_ev) m_ovf = 1;
    else if (clr) m_ovf = 0;
  endtask

  task automatic check_outputs();
    check_val("tx_start", tx_start_o, exp_start);
    check_val("tx_data", tx_data_o, m_data);
    check_val("count", count_o, mq.size());
    check_val("empty", empty_o, mq.size() == 0);
    check_val("full", full_o, mq.size() == DEPTH);
    check_val("overflow", overflow_o, m_ovf);
    check_val("timeout", timeout_o, exp_to);
  endtask

  task automatic step(input bit rx, input bit err, input logic [7:0] d, input bit te, input bit clr);
    rx_end_i = rx; rx_err_i = err; rx_data_i = d; tx_end_i = te; clr_ovf_i = clr;
    model_edge(rx, err, d, te, clr);
    @(negedge sysclk);
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 8'h00, 0, 0);
  endtask

  task automatic do_reset();
    @(posedge sysclk);
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
    rx_end_i = 0; rx_err_i = 0; tx_end_i = 0; clr_ovf_i = 0;
    @(negedge sysclk);
    @(negedge sysclk);
    check_outputs();
    reset_n = 1'b1;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((mq.size() > 0 || m_busy) && n < budget) begin
      step(0, 0, 8'h00, m_waiting && ($urandom_range(0, 3) == 0), 0);
      n++;
    end
    check_val("drain_budget", n < budget, 1);
  endtask

  initial begin
    int n_to, n_st;
    model_reset();
    do_reset();

    // single byte: start pulse three edges after the push
    step(1, 0, 8'h41, 0, 0);
    step(0, 0, 8'h00, 0, 0);
    step(0, 0, 8'h00, 0, 0);
    check_val("lat_start", tx_start_o, 1);
    check_val("lat_data", tx_data_o, 8'h41);
    idle(49);
    step(0, 0, 8'h00, 1, 0);
    idle(2);
    check_val("empty_after", empty_o, 1);

    // fill: 17 pushes leave 16 queued, the 18th overflows even with a same-edge clear
    for (int i = 0; i < 17; i++) step(1, 0, 8'(i), 0, 0);
    check_val("full_17", full_o, 1);
    check_val("ovf_17", overflow_o, 0);
    step(1, 0, 8'h11, 0, 1);
    check_val("ovf_18", overflow_o, 1);
    check_val("count_18", count_o, 16);

    // full FIFO: push on the IDLE pop edge keeps count at 16
    step(0, 0, 8'h00, 1, 1);
    step(1, 0, 8'hA5, 0, 0);
    check_val("count_pushpop", count_o, 16);
    drain(4000);

    // timeout: two bytes, no tx_end
    step(1, 0, 8'h21, 0, 0);
    step(1, 0, 8'h22, 0, 0);
    n_to = 0;
    for (int i = 0; i < 250; i++) begin
      step(0, 0, 8'h00, 0, 0);
      if (timeout_o) n_to++;
    end
    check_val("timeout_pulses", n_to, 2);

    // errored byte
    step(1, 1, 8'h55, 0, 0);
`ifdef UART_TX_QUEUE_ERR_DROP_EN
    check_val("err_count", count_o, 0);
`else
    check_val("err_count", count_o, 1);
`endif
    drain(500);

    // reset during WAIT with 3 queued
    for (int i = 0; i < 4; i++) step(1, 0, 8'h60 + 8'(i), 0, 0);
    idle(3);
    do_reset();
    n_st = 0;
    for (int i = 0; i < 30; i++) begin
      step(0, 0, 8'h00, $urandom_range(0, 1), 0);
      if (tx_start_o) n_st++;
    end
    check_val("no_start_after_rst", n_st, 0);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 9) < 3, $urandom_range(0, 4) == 0, 8'($urandom),
           $urandom_range(0, 9) == 0, $urandom_range(0, 19) == 0);
    end
    drain(4000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
